// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between execute (port 0) and address-gen (port 1).
// Latency: result registered on the grant edge, visible on rsp_* the following cycle.
// Backpressure: new grants only when the response slot is empty or draining; otherwise both readys stay low.
//
// Ports:
//   clk, rst_n                     clock and async active-low reset
//   reqN_valid/ready/a/b/op/tag    request ports (N = 0 execute, N = 1 address generation)
//   alu_a, alu_b, alu_op           operand/op drive to the shared ALU (zero when nothing is granted)
//   alu_result                     combinational ALU result
//   rsp_valid/ready/id/tag/result  single registered response slot
module alu_share_arbiter #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic [3:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   input  logic [3:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [3:0]       alu_op,
   input  logic [XLEN-1:0]  alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [XLEN-1:0]  rsp_result
);

   // Priority pointer: index of the port that wins when both are valid.
   logic             ptr_q, ptr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic [XLEN-1:0]  rsp_result_q, rsp_result_d;

   logic can_accept;
   logic gnt0, gnt1;

   always_comb begin
      can_accept = !rsp_valid_q || rsp_ready;
      // rst_n gates the grant so nothing is handed out while reset is held,
      // even though the slot reads empty during that time.
      gnt0 = rst_n && can_accept && req0_valid && (!req1_valid || !ptr_q);
      gnt1 = rst_n && can_accept && req1_valid && (!req0_valid || ptr_q);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // ALU drive: granted request's fields, quiet zeros otherwise.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (gnt0) begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_op = req0_op;
      end else if (gnt1) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_op = req1_op;
      end
   end

   always_comb begin
      ptr_d        = ptr_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_result_d = rsp_result_q;
      if (gnt0 || gnt1) begin
         // Any grant hands priority to the other port; a grant while the slot
         // drains reloads it in the same cycle for one result per cycle.
         ptr_d        = gnt0;
         rsp_valid_d  = 1'b1;
         rsp_id_d     = gnt1;
         rsp_tag_d    = gnt1 ? req1_tag : req0_tag;
         rsp_result_d = alu_result;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_result_q <= '0;
      end else begin
         ptr_q        <= ptr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_result_q <= rsp_result_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   localparam int XLEN  = 64;
   localparam int TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]       req0_op, req1_op;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic [XLEN-1:0]  alu_a, alu_b, alu_result;
   logic [3:0]       alu_op;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic [XLEN-1:0]  rsp_result;

   alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .req1_tag(req1_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic meaning of each op: SHnADD = a + (b << n), modulo 2^XLEN; others give 0.
   function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a + (b << 1);
         4'd3:    return a + (b << 2);
         4'd4:    return a + (b << 3);
         default: return '0;
      endcase
   endfunction

   // Stand-in for the shared combinational ALU.
   always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

   typedef struct {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  res;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: slot occupancy and which port was granted most recently.
   bit m_vld  = 1'b0;
   bit m_last = 1'b1;   // "port 1 last" so port 0 wins the first contention
   bit g0_last, g1_last;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Compare DUT arbitration against the model for the current cycle, then advance the model.
   task automatic model_step();
      bit can, g0, g1;
      can = !m_vld || rsp_ready;
      g0 = 1'b0;
      g1 = 1'b0;
      if (can) begin
         if (req0_valid && req1_valid) begin
            if (m_last) g0 = 1'b1; else g1 = 1'b1;
         end else if (req0_valid) g0 = 1'b1;
         else if (req1_valid) g1 = 1'b1;
      end
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_vld});
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
      chk("alu_a", alu_a, g0 ? req0_a : (g1 ? req1_a : '0));
      chk("alu_b", alu_b, g0 ? req0_b : (g1 ? req1_b : '0));
      chk("alu_op", {60'd0, alu_op}, {60'd0, g0 ? req0_op : (g1 ? req1_op : 4'd0)});
      if (g0 || g1) begin
         exp_t e;
         e.id  = g1;
         e.tag = g1 ? req1_tag : req0_tag;
         e.res = g1 ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
         sb.push_back(e);
         m_last = g1;
         m_vld  = 1'b1;
      end else if (rsp_ready) begin
         m_vld = 1'b0;
      end
      g0_last = g0;
      g1_last = g1;
   endtask

   // Inputs change at posedge+1; checks happen at the falling edge.
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb.delete();
      m_vld  = 1'b0;
      m_last = 1'b1;
   endtask

   // Monitor: every delivered response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: response id=%0d tag=%h res=%h with nothing expected",
                     rsp_id, rsp_tag, rsp_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
            chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
            chk("rsp_result", rsp_result, e.res);
         end
      end
   end

   function automatic logic [XLEN-1:0] rnd64();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return XLEN'($urandom_range(0, 15));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [3:0] rnd_op();
      if ($urandom_range(0, 4) == 0) return 4'($urandom_range(5, 15));
      return 4'($urandom_range(0, 4));
   endfunction

   logic [XLEN-1:0] held;

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_tag = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_tag = 0;
      rsp_ready = 1'b1;

      // Reset held 3 cycles, with both valids asserted to show nothing is granted.
      @(posedge clk); #1;
      req0_valid = 1; req1_valid = 1; req0_a = 7; req1_b = 9; req0_op = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
         chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
         chk("rst_alu", alu_a | alu_b | {60'd0, alu_op}, 64'd0);
         chk("rst_rsp_fields", rsp_result | {60'd0, rsp_tag} | {63'd0, rsp_id}, 64'd0);
         @(posedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0; req0_a = 0; req1_b = 0; req0_op = 0;
      rst_n = 1'b1;
      model_reset();
      repeat (2) tick();

      // Contention from reset: grants alternate 0,1,0,1.
      req0_valid = 1; req0_op = 4'd0; req0_a = 1; req0_b = 1; req0_tag = 4'd1;
      req1_valid = 1; req1_op = 4'd2; req1_a = 1; req1_b = 1; req1_tag = 4'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("cont_order", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
         if (i > 0) chk("cont_result", rsp_result, (i % 2 == 1) ? 64'd2 : 64'd3);
         model_step();
         @(posedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0;
      tick();

      // Single port back-to-back, with wrap-around on SUB.
      req0_valid = 1; req0_op = 4'd4; req0_a = 64'h10; req0_b = 64'h2; req0_tag = 4'd3;
      tick();
      req0_op = 4'd1; req0_a = 64'd0; req0_b = 64'd1; req0_tag = 4'd4;
      @(negedge clk);
      chk("b2b_res0", rsp_result, 64'h20);
      chk("b2b_id0", {63'd0, rsp_id}, 64'd0);
      chk("b2b_tag0", {60'd0, rsp_tag}, 64'd3);
      model_step();
      @(posedge clk); #1;
      req0_valid = 0;
      @(negedge clk);
      chk("b2b_res1", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("b2b_tag1", {60'd0, rsp_tag}, 64'd4);
      model_step();
      @(posedge clk); #1;

      // Backpressure: one accept, then slot frozen, then drain+reload in one cycle.
      req0_valid = 1; req0_op = 4'd0; req0_a = 64'd5; req0_b = 64'd6; req0_tag = 4'd5;
      req1_valid = 1; req1_op = 4'd3; req1_a = 64'd1; req1_b = 64'd2; req1_tag = 4'd6;
      rsp_ready = 0;
      tick();
      held = rsp_result;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("bp_stable", rsp_result, held);
      end
      if (g0_last) req0_valid = 0;
      if (g1_last) req1_valid = 0;
      rsp_ready = 1;
      tick();
      req0_valid = 0; req1_valid = 0;
      repeat (2) tick();

      // Unsupported op goes through and returns 0.
      req1_valid = 1; req1_op = 4'hF; req1_a = 64'd5; req1_b = 64'd7; req1_tag = 4'd9;
      tick();
      req1_valid = 0;
      @(negedge clk);
      chk("badop_res", rsp_result, 64'd0);
      chk("badop_id", {63'd0, rsp_id}, 64'd1);
      model_step();
      @(posedge clk); #1;

      // Mid-operation asynchronous reset with a response held under backpressure.
      req0_valid = 1; req0_op = 4'd0; req0_a = 64'd3; req0_b = 64'd4; req0_tag = 4'd7;
      rsp_ready = 0;
      tick();
      req0_valid = 0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {63'd0, rsp_valid}, 64'd0);
      model_reset();
      rst_n = 1'b1;
      req0_valid = 1; req0_tag = 4'd8;
      req1_valid = 1; req1_op = 4'd1; req1_a = 64'd9; req1_b = 64'd4; req1_tag = 4'd10;
      rsp_ready = 1;
      @(negedge clk);
      chk("midrst_grant0", {62'd0, req1_ready, req0_ready}, 64'd1);
      model_step();
      @(posedge clk); #1;
      req0_valid = 0;
      tick();
      req1_valid = 0;
      tick();

      // Randomized traffic; requests hold while valid and not yet accepted.
      for (int i = 0; i < 2000; i++) begin
         if (!(req0_valid && !g0_last)) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req0_a = rnd64(); req0_b = rnd64(); req0_op = rnd_op(); req0_tag = 4'($urandom);
         end
         if (!(req1_valid && !g1_last)) begin
            req1_valid = ($urandom_range(0, 9) < 7);
            req1_a = rnd64(); req1_b = rnd64(); req1_op = rnd_op(); req1_tag = 4'($urandom);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end

      req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      repeat (3) tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
